// File: rtl/stage_memory.sv
// Memory pipeline stage: issues one data-bus access per load/store and registers
// results for writeback. Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module stage_memory (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  ex_result_src,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  input  logic [31:0] ex_instr_addr_plus,
  input  logic        ex_regfile_wr_enable,
  input  logic        ex_mem_rd_enable,
  input  logic        ex_mem_wr_enable,
  input  logic [2:0]  ex_funct3,
  output logic [4:0]  mem_rd,
  output logic [1:0]  mem_result_src,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_instr_addr_plus,
  output logic        mem_regfile_wr_enable,
  output logic [31:0] mem_read_data,
  output logic        mem_stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic        mem_misaligned,
`endif
  output logic [1:0]  dbg_state_o   // 0 IDLE, 1 REQ, 2 WAIT
);

  // Handshake: dbus_req with addr/we/be/wdata stays stable until the cycle
  // dbus_gnt=1; a load's data returns later with a single dbus_rvalid pulse.
  // gnt seen outside IDLE/REQ and rvalid seen outside WAIT are ignored.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0]  cap_rd_q;
  logic [1:0]  cap_src_q;
  logic [31:0] cap_alu_q;
  logic [31:0] cap_wdata_q;
  logic [31:0] cap_pc4_q;
  logic        cap_we_q;
  logic [2:0]  cap_funct3_q;
  logic        cap_store_q;

  logic [4:0]  mem_rd_q;
  logic [1:0]  mem_src_q;
  logic [31:0] mem_alu_q;
  logic [31:0] mem_pc4_q;
  logic        mem_we_q;
  logic [31:0] mem_rdata_q;

  logic        is_idle;
  logic        ex_mem_op;
  logic        misaligned;
  logic        start_access;
  logic [4:0]  op_rd;
  logic [1:0]  op_src;
  logic [31:0] op_alu;
  logic [31:0] op_wdata;
  logic [31:0] op_pc4;
  logic        op_we;
  logic [2:0]  op_funct3;
  logic        op_store;
  logic        retire_pass;
  logic        retire_store;
  logic        retire_load;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  assign is_idle   = (state_q == S_IDLE);
  assign ex_mem_op = ex_mem_rd_enable | ex_mem_wr_enable;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ex_mem_op &&
                      (((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                       (ex_funct3[1] && (ex_alu_result[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign start_access = ex_mem_op & ~misaligned;

  // In IDLE the request is driven straight from ex_*; afterwards from the captured copy.
  assign op_rd     = is_idle ? ex_rd                : cap_rd_q;
  assign op_src    = is_idle ? ex_result_src        : cap_src_q;
  assign op_alu    = is_idle ? ex_alu_result        : cap_alu_q;
  assign op_wdata  = is_idle ? ex_write_data        : cap_wdata_q;
  assign op_pc4    = is_idle ? ex_instr_addr_plus   : cap_pc4_q;
  assign op_we     = is_idle ? ex_regfile_wr_enable : cap_we_q;
  assign op_funct3 = is_idle ? ex_funct3            : cap_funct3_q;
  assign op_store  = is_idle ? ex_mem_wr_enable     : cap_store_q;

  always_comb begin
    state_d      = state_q;
    dbus_req     = 1'b0;
    mem_stall    = 1'b0;
    retire_pass  = 1'b0;
    retire_store = 1'b0;
    retire_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_access) begin
          dbus_req = 1'b1;
          if (op_store && dbus_gnt) begin
            retire_store = 1'b1;
          end else begin
            mem_stall = 1'b1;
            state_d   = dbus_gnt ? S_WAIT : S_REQ;
          end
        end else begin
          retire_pass = 1'b1;
        end
      end
      S_REQ: begin
        dbus_req = 1'b1;
        if (dbus_gnt && op_store) begin
          retire_store = 1'b1;
          state_d      = S_IDLE;
        end else begin
          mem_stall = 1'b1;
          if (dbus_gnt) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dbus_rvalid) begin
          retire_load = 1'b1;
          state_d     = S_IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte lanes and write-data replication; half uses addr[1], word always lane 0.
  always_comb begin
    dbus_be    = 4'b1111;
    dbus_wdata = op_wdata;
    case (op_funct3[1:0])
      2'b00: begin
        dbus_be    = 4'b0001 << op_alu[1:0];
        dbus_wdata = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        dbus_be    = op_alu[1] ? 4'b1100 : 4'b0011;
        dbus_wdata = {2{op_wdata[15:0]}};
      end
      default: begin
        dbus_be    = 4'b1111;
        dbus_wdata = op_wdata;
      end
    endcase
  end

  assign dbus_addr = {op_alu[31:2], 2'b00};
  assign dbus_we   = dbus_req & op_store;

  always_comb begin
    load_byte = dbus_rdata[7:0];
    case (op_alu[1:0])
      2'b00:   load_byte = dbus_rdata[7:0];
      2'b01:   load_byte = dbus_rdata[15:8];
      2'b10:   load_byte = dbus_rdata[23:16];
      default: load_byte = dbus_rdata[31:24];
    endcase
    load_half = op_alu[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (op_funct3)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b100:  load_ext = {24'd0, load_byte};
      3'b101:  load_ext = {16'd0, load_half};
      default: load_ext = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cap_rd_q     <= '0;
      cap_src_q    <= '0;
      cap_alu_q    <= '0;
      cap_wdata_q  <= '0;
      cap_pc4_q    <= '0;
      cap_we_q     <= 1'b0;
      cap_funct3_q <= '0;
      cap_store_q  <= 1'b0;
      mem_rd_q     <= '0;
      mem_src_q    <= '0;
      mem_alu_q    <= '0;
      mem_pc4_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (is_idle) begin
        cap_rd_q     <= ex_rd;
        cap_src_q    <= ex_result_src;
        cap_alu_q    <= ex_alu_result;
        cap_wdata_q  <= ex_write_data;
        cap_pc4_q    <= ex_instr_addr_plus;
        cap_we_q     <= ex_regfile_wr_enable;
        cap_funct3_q <= ex_funct3;
        cap_store_q  <= ex_mem_wr_enable;
      end
      if (retire_pass || retire_store || retire_load) begin
        mem_rd_q  <= op_rd;
        mem_src_q <= op_src;
        mem_alu_q <= op_alu;
        mem_pc4_q <= op_pc4;
        mem_we_q  <= op_we & ~retire_store & ~misaligned;
      end
      if (retire_load) mem_rdata_q <= load_ext;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misaligned_q <= 1'b0;
    else     misaligned_q <= retire_pass & misaligned;
  end

  assign mem_misaligned = misaligned_q;
`endif

  assign mem_rd                = mem_rd_q;
  assign mem_result_src        = mem_src_q;
  assign mem_alu_result        = mem_alu_q;
  assign mem_instr_addr_plus   = mem_pc4_q;
  assign mem_regfile_wr_enable = mem_we_q;
  assign mem_read_data         = mem_rdata_q;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: bench-side bus responder plus a
// transaction-level reference model; build with +define+MISALIGN_TRAP_EN for the trap variant.
module tb_stage_memory;

  logic        clk;
  logic        rst;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_result_src;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_write_data;
  logic [31:0] ex_instr_addr_plus;
  logic        ex_regfile_wr_enable;
  logic        ex_mem_rd_enable;
  logic        ex_mem_wr_enable;
  logic [2:0]  ex_funct3;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_instr_addr_plus;
  logic        mem_regfile_wr_enable;
  logic [31:0] mem_read_data;
  logic        mem_stall;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic [1:0]  dbg_state_o;
`ifdef MISALIGN_TRAP_EN
  logic        mem_misaligned;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_alu;

  stage_memory dut (
    .clk(clk), .rst(rst),
    .ex_rd(ex_rd), .ex_result_src(ex_result_src), .ex_alu_result(ex_alu_result),
    .ex_write_data(ex_write_data), .ex_instr_addr_plus(ex_instr_addr_plus),
    .ex_regfile_wr_enable(ex_regfile_wr_enable), .ex_mem_rd_enable(ex_mem_rd_enable),
    .ex_mem_wr_enable(ex_mem_wr_enable), .ex_funct3(ex_funct3),
    .mem_rd(mem_rd), .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_instr_addr_plus(mem_instr_addr_plus), .mem_regfile_wr_enable(mem_regfile_wr_enable),
    .mem_read_data(mem_read_data), .mem_stall(mem_stall),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata),
`ifdef MISALIGN_TRAP_EN
    .mem_misaligned(mem_misaligned),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit ref_misaligned(input bit mem_op, input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return mem_op && ((size_of(f3) == 2 && a[0]) || (size_of(f3) == 4 && a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] m;
    if (size_of(f3) == 1)      m = 32'd1 << a[1:0];
    else if (size_of(f3) == 2) m = 32'd3 << (2 * a[1]);
    else                       m = 32'd15;
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (size_of(f3) == 1)      return (d & 32'hFF) * 32'h0101_0101;
    else if (size_of(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    else                       return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  // ---------------- driver ----------------
  // kind: 0 non-memory, 1 load, 2 store. Also acts as the bus slave.
  task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata,
                       input int gnt_dly, input int rv_dly);
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] pc4;
    logic        we;
    bit ld, st, mis;
    int stalls;
    rd  = 5'($urandom_range(0, 31));
    src = 2'($urandom_range(0, 3));
    pc4 = $urandom;
    we  = 1'($urandom_range(0, 1));
    ld  = (kind == 1);
    st  = (kind == 2);
    mis = ref_misaligned(ld || st, f3, addr);
    ex_rd = rd; ex_result_src = src; ex_alu_result = addr; ex_write_data = wd;
    ex_instr_addr_plus = pc4; ex_regfile_wr_enable = we; ex_funct3 = f3;
    ex_mem_rd_enable = ld; ex_mem_wr_enable = st;
    stalls = 0;
    if (!(ld || st) || mis) begin
      dbus_gnt = 1'($urandom_range(0, 1));
      dbus_rvalid = 1'($urandom_range(0, 1));
      dbus_rdata = $urandom;
      #1;
      check("pass_req", dbus_req, 0);
      check("pass_stall", mem_stall, 0);
      check("pass_hold_alu", mem_alu_result, last_alu);
      @(negedge clk);
    end else begin
      if (ld) exp_q.push_back(ref_load(f3, addr, rdata));
      for (int c = 0; c <= gnt_dly; c++) begin
        dbus_gnt = (c == gnt_dly);
        dbus_rvalid = 1'($urandom_range(0, 1));
        dbus_rdata = $urandom;
        #1;
        check("req", dbus_req, 1);
        check("req_addr", dbus_addr, addr & 32'hFFFF_FFFC);
        check("req_we", dbus_we, st);
        check("req_be", dbus_be, ref_be(f3, addr));
        if (st) check("req_wdata", dbus_wdata, ref_wdata(f3, wd));
        check("req_stall", mem_stall, !(st && c == gnt_dly));
        check("req_hold_alu", mem_alu_result, last_alu);
        if (mem_stall) stalls++;
        @(negedge clk);
      end
      if (ld) begin
        for (int c = 0; c <= rv_dly; c++) begin
          dbus_gnt = 1'($urandom_range(0, 1));
          dbus_rvalid = (c == rv_dly);
          dbus_rdata = (c == rv_dly) ? rdata : $urandom;
          #1;
          check("wait_req", dbus_req, 0);
          check("wait_stall", mem_stall, c != rv_dly);
          check("wait_hold_alu", mem_alu_result, last_alu);
          if (mem_stall) stalls++;
          @(negedge clk);
        end
      end
      check("stall_cycles", stalls, ld ? gnt_dly + 1 + rv_dly : gnt_dly);
    end
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b0;
    check("mem_rd", mem_rd, rd);
    check("mem_src", mem_result_src, src);
    check("mem_alu", mem_alu_result, addr);
    check("mem_pc4", mem_instr_addr_plus, pc4);
    check("mem_we", mem_regfile_wr_enable, (st || mis) ? 1'b0 : we);
    if (ld && !mis) check("mem_read_data", mem_read_data, exp_q.pop_front());
`ifdef MISALIGN_TRAP_EN
    check("mem_misaligned", mem_misaligned, mis);
`endif
    last_alu = addr;
  endtask

  task automatic drive_idle();
    ex_rd = '0; ex_result_src = '0; ex_alu_result = '0; ex_write_data = '0;
    ex_instr_addr_plus = '0; ex_regfile_wr_enable = 1'b0; ex_funct3 = '0;
    ex_mem_rd_enable = 1'b0; ex_mem_wr_enable = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, dbg_state_o, 0);
    check({tag, "_rd"}, mem_rd, 0);
    check({tag, "_src"}, mem_result_src, 0);
    check({tag, "_alu"}, mem_alu_result, 0);
    check({tag, "_pc4"}, mem_instr_addr_plus, 0);
    check({tag, "_we"}, mem_regfile_wr_enable, 0);
    check({tag, "_rdata"}, mem_read_data, 0);
    check({tag, "_req"}, dbus_req, 0);
    check({tag, "_stall"}, mem_stall, 0);
`ifdef MISALIGN_TRAP_EN
    check({tag, "_mis"}, mem_misaligned, 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] ld_codes [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
  logic [2:0] st_codes [4] = '{3'b000, 3'b001, 3'b010, 3'b011};

  initial begin
    rst = 1'b1;
    drive_idle();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    last_alu = '0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    do_op(0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0);
    check("nonmem_alu", mem_alu_result, 32'h0000_1234);
    do_op(1, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 2, 1);
    check("lb_0x103", mem_read_data, 32'hFFFF_FF80);
    do_op(2, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, 0);
    check("sh_we", mem_regfile_wr_enable, 0);
    do_op(1, 3'b101, 32'h0000_0000, 32'h0, 32'h0000_9ABC, 0, 0);
    check("lhu_0x000", mem_read_data, 32'h0000_9ABC);
    do_op(2, 3'b000, 32'h0000_0011, 32'h0000_005A, 32'h0, 0, 0);
`ifdef MISALIGN_TRAP_EN
    do_op(1, 3'b010, 32'h0000_0006, 32'h0, 32'h1111_2222, 0, 0);
    check("lw_0x006_mis", mem_misaligned, 1);
`endif

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      f3 = (kind == 2) ? st_codes[$urandom_range(0, 3)] : ld_codes[$urandom_range(0, 7)];
      do_op(kind, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset while waiting for read data, then a stray rvalid
    ex_rd = 5'd7; ex_result_src = 2'd1; ex_alu_result = 32'h0000_0400;
    ex_instr_addr_plus = 32'h0000_0104; ex_regfile_wr_enable = 1'b1;
    ex_funct3 = 3'b010; ex_mem_rd_enable = 1'b1; ex_mem_wr_enable = 1'b0;
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    #1;
    check("wait_before_rst_stall", mem_stall, 1);
    rst = 1'b1;
    drive_idle();
    #1;
    check_all_zero("rst_in_wait");
    @(negedge clk);
    rst = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dbus_rvalid = 1'b0;
    #1;
    check_all_zero("late_rvalid");
    last_alu = '0;

    do_op(1, 3'b100, 32'h0000_0021, 32'h0, 32'h0000_C300, 1, 2);
    check("lbu_after_rst", mem_read_data, 32'h0000_00C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
